pio_poll_master: RTL and testbench

//   Avalon-MM read initiator that periodically polls a PIO input slave (e.g. the

---
 rtl/pio_poll_master.sv | 164 ++++++++++++++++
 tb/tb_pio_poll_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_poll_master.sv
// Avalon-MM read initiator that polls a PIO data register at a fixed interval.
// It forwards only changed samples to a valid/ready consumer stream.
module pio_poll_master #(
    parameter int ADDR_W       = 2,
    parameter int POLL_ADDR    = 0,
    parameter int DATA_W       = 10,
    parameter int POLL_DIV     = 50000,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] value,
    output logic              value_valid,
    input  logic              value_ready,
    output logic              changed,
    output logic              timeout_err
);

    localparam int DIV_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(POLL_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(READ_LATENCY - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LAT  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [TO_W-1:0]   wait_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              first_flag;

    logic              start;
    logic              accept;
    logic              abort;
    logic              sample_now;
    logic              pending;
    logic              taken;
    logic              update;
    logic [DATA_W-1:0] sample;

    assign avm_address = ADDR_W'(POLL_ADDR);
    assign sample      = avm_readdata[DATA_W-1:0];
    assign taken       = value_valid && value_ready;
    // A value being taken on this edge no longer blocks the next poll.
    assign pending     = value_valid && !value_ready;
    assign update      = sample_now && (first_flag || (sample != value));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        avm_read   = 1'b0;
        start      = 1'b0;
        accept     = 1'b0;
        abort      = 1'b0;
        sample_now = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (div_cnt == '0)) begin
                    if (pending) begin
                        state_nxt = HOLD;
                    end else begin
                        start     = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            HOLD: begin
                if (enable && !pending) begin
                    start     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    accept    = 1'b1;
                    state_nxt = LAT;
                end else if (wait_cnt == TO_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            LAT: begin
                if (lat_cnt == '0) begin
                    sample_now = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The divider runs in every state so the poll period stays POLL_DIV
    // cycles regardless of how long the read itself takes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= DIV_RELOAD;
        end else if (start) begin
            div_cnt <= DIV_RELOAD;
        end else if (enable && (div_cnt != '0)) begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            if (start) begin
                wait_cnt <= '0;
            end else if ((state == REQ) && avm_waitrequest && !abort) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (accept) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state == LAT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value       <= '0;
            value_valid <= 1'b0;
            changed     <= 1'b0;
            timeout_err <= 1'b0;
            first_flag  <= 1'b1;
        end else begin
            changed     <= update;
            timeout_err <= abort;
            if (update) begin
                value       <= sample;
                value_valid <= 1'b1;
                first_flag  <= 1'b0;
            end else if (taken) begin
                value_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pio_poll_master.sv
// Directed bench for pio_poll_master: stimulus pushes expected samples into a
// queue and a monitor pops one on every changed pulse.
module tb_pio_poll_master;

    localparam int DATA_W = 10;

    logic              clk;
    logic              reset_n;
    logic              enable;
    logic [1:0]        avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic [DATA_W-1:0] value;
    logic              value_valid;
    logic              value_ready;
    logic              changed;
    logic              timeout_err;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q[$];

    pio_poll_master #(
        .ADDR_W(2), .POLL_ADDR(0), .DATA_W(DATA_W),
        .POLL_DIV(4), .READ_LATENCY(1), .TIMEOUT(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .value(value), .value_valid(value_valid), .value_ready(value_ready),
        .changed(changed), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_read(input int max, output int n);
        n = 0;
        while (!avm_read && n < max) begin
            tick();
            n++;
        end
        if (!avm_read) check("read_wait_expired", 0, 1);
    endtask

    task automatic wait_valid(input int max);
        int n;
        n = 0;
        while (!value_valid && n < max) begin
            tick();
            n++;
        end
        if (!value_valid) check("valid_wait_expired", 0, 1);
    endtask

    // Monitor: every changed pulse must match the oldest expected sample.
    logic prev_changed = 1'b0;
    always @(negedge clk) begin
        if (prev_changed) check("changed_width", {31'd0, changed}, 0);
        if (reset_n && changed) begin
            if (exp_q.size() == 0) begin
                check("unexpected_change", {22'd0, value}, 32'hDEAD);
            end else begin
                check("sample_value", {22'd0, value}, {22'd0, exp_q.pop_front()});
                check("sample_valid", {31'd0, value_valid}, 1);
            end
        end
        prev_changed = reset_n && changed;
    end

    initial begin
        int n;
        int held;
        int cnt;
        logic prev_rd;

        reset_n = 1'b0; enable = 1'b1; avm_waitrequest = 1'b0;
        avm_readdata = 32'h0; value_ready = 1'b0;
        tick(); tick();
        check("rst_read",    {31'd0, avm_read}, 0);
        check("rst_value",   {22'd0, value}, 0);
        check("rst_valid",   {31'd0, value_valid}, 0);
        check("rst_changed", {31'd0, changed}, 0);
        check("rst_timeout", {31'd0, timeout_err}, 0);

        // 1: first poll after reset always reports, even a zero sample
        exp_q.push_back(10'h000);
        reset_n = 1'b1;
        wait_read(20, n);
        check("first_read_delay", n, 4);
        check("poll_address", {30'd0, avm_address}, 0);
        wait_valid(10);

        // 5 (part): pending value blocks further polling
        avm_readdata = 32'h155;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (avm_read) cnt++;
        end
        check("pending_no_read", cnt, 0);
        check("pending_valid", {31'd0, value_valid}, 1);

        // 2: consume, new value 0x155; identical samples afterwards are filtered
        exp_q.push_back(10'h155);
        value_ready = 1'b1;
        tick();
        check("read_after_take", {31'd0, avm_read}, 1);
        wait_valid(10);
        cnt = 0; held = 0; prev_rd = avm_read;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (value_valid) cnt++;
            if (avm_read && !prev_rd) held++;
            prev_rd = avm_read;
        end
        check("unchanged_no_valid", cnt, 0);
        check("poll_rises_in_20", held, 5);

        // 3: three stalled cycles, upper readdata bits dropped
        avm_readdata = 32'hFFFF_F3FF;
        avm_waitrequest = 1'b1;
        exp_q.push_back(10'h3FF);
        wait_read(20, n);
        check("stall_address", {30'd0, avm_address}, 0);
        held = 0;
        while (avm_read && held < 20) begin
            held++;
            if (held == 4) avm_waitrequest = 1'b0;
            tick();
        end
        check("stall_read_held", held, 4);
        check("no_change_in_lat", {31'd0, changed}, 0);
        tick();
        check("change_after_lat", {31'd0, changed}, 1);

        // 4: waitrequest stuck -> abort after TIMEOUT cycles
        avm_waitrequest = 1'b1;
        wait_read(20, n);
        held = 0;
        while (avm_read && held < 20) begin
            held++;
            tick();
        end
        check("timeout_read_held", held, 5);
        check("timeout_pulse", {31'd0, timeout_err}, 1);
        check("timeout_value", {22'd0, value}, 32'h3FF);
        avm_waitrequest = 1'b0;
        avm_readdata = 32'h0AA;
        value_ready = 1'b0;
        exp_q.push_back(10'h0AA);
        tick();
        check("timeout_pulse_end", {31'd0, timeout_err}, 0);
        wait_valid(20);

        // 5: backpressure holds the pending value, release restarts polling
        avm_readdata = 32'h2AA;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (avm_read) cnt++;
        end
        check("bp_no_read", cnt, 0);
        check("bp_value_stable", {22'd0, value}, 32'h0AA);
        exp_q.push_back(10'h2AA);
        value_ready = 1'b1;
        tick();
        value_ready = 1'b0;
        check("bp_valid_cleared", {31'd0, value_valid}, 0);
        check("bp_read_restart", {31'd0, avm_read}, 1);
        wait_valid(10);

        // 6: enable dropped mid-read lets the read finish, then halts polling
        value_ready = 1'b1;
        avm_readdata = 32'h111;
        avm_waitrequest = 1'b1;
        exp_q.push_back(10'h111);
        tick();
        wait_read(20, n);
        enable = 1'b0;
        tick(); tick();
        avm_waitrequest = 1'b0;
        wait_valid(10);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (avm_read) cnt++;
        end
        check("disabled_no_read", cnt, 0);
        enable = 1'b1;
        wait_read(10, n);

        // reset while in LAT discards the in-flight sample
        avm_readdata = 32'h222;
        tick();
        reset_n = 1'b0;
        #1;
        check("lat_rst_read",    {31'd0, avm_read}, 0);
        check("lat_rst_valid",   {31'd0, value_valid}, 0);
        check("lat_rst_value",   {22'd0, value}, 0);
        check("lat_rst_changed", {31'd0, changed}, 0);
        tick(); tick();
        check("lat_rst_hold_valid", {31'd0, value_valid}, 0);
        exp_q.push_back(10'h222);
        reset_n = 1'b1;
        wait_valid(20);
        tick(); tick();

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
